muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the shared multi-cycle multiply and divide units feeding the HI/LO registers. It sits beside the execute stage and accepts one mult/multu/div/divu/mthi/mtlo operation at a time. It drives the fixed-latency multiplier and the start/ready iterative divider, holds the pipeline through stallreq, and emits HI/LO write strobes plus data for the register file and forwarding path.

## Interface
- MUL_LAT, 1: multiplier latency in cycles from first operand presentation to valid mul_result; legal 0..14.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  abort current operation; no HI/LO write
- pipe_stall  in  1  execute stage held by another stage this cycle
- op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo  in  1 each  operation select; at most one high
- src_a, src_b  in  32 each  rs / rt operands
- stallreq  out  1  hold execute stage
- hi_we, lo_we  out  1 each  HI/LO write strobes
- hi_wdata, lo_wdata  out  32 each  HI/LO write data
- mul_signed  out  1  signed multiply
- mul_ina, mul_inb  out  32 each  multiplier operands
- mul_result  in  64  {hi, lo} product
- div_start, div_annul, div_signed  out  1 each  divider control
- div_opa, div_opb  out  32 each  dividend / divisor
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid this cycle

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- **IDLE**
  - op_mthi: hi_we=1, hi_wdata=src_a, combinational, no stall. op_mtlo is the same on the LO side.
  - Repeated writes while pipe_stall is high are permitted.
  - mult/multu/div/divu: capture src_a, src_b and signedness. stallreq=1 combinational in the accept cycle. Next state is MUL_RUN or DIV_RUN.
  - flush high: ignore all ops, stallreq=0.
- **MUL_RUN**
  - mul_ina/mul_inb come from the capture registers and are held stable. Counter loads MUL_LAT at entry.
  - When the counter reaches 0: capture mul_result into the result registers and go to DONE.
  - Outside MUL_RUN, mul_ina/mul_inb/mul_signed are 0.
- **DIV_RUN**
  - div_start=1 and div_opa/div_opb/div_signed come from the capture registers, all held until the div_ready cycle.
  - On div_ready=1: div_start=0, capture HI=div_result[63:32] and LO=div_result[31:0], go to DONE.
  - Outside DIV_RUN, div_opa/div_opb/div_signed are 0.
- **DONE**
  - stallreq=0.
  - First DONE cycle only: hi_we=lo_we=1, wdata from the result registers.
  - Stay in DONE while pipe_stall=1, so the same instruction is never restarted. Go to IDLE when pipe_stall=0.
- **stallreq**: 1 in the accept cycle, MUL_RUN and DIV_RUN; 0 otherwise.
- **flush**: from any state, go to IDLE next cycle and suppress we in the same cycle. If flush arrives in DIV_RUN, div_annul=1 for that cycle.
- **flush coincident with div_ready or the final MUL_RUN cycle**: flush wins; no write.
- **Reset mid-operation**: go to IDLE and zero all registers. The divider is reset by the shared rst, not annulled.

## Timing
- All outputs are 0 in the reset cycle and in IDLE with no op.
- mult, MUL_LAT=L:
  - accept cycle 0;
  - MUL_RUN cycles 1..1+L;
  - DONE cycle 2+L, with we;
  - the execute stage stalls L+2 cycles.
- div: accept cycle 0; DIV_RUN from cycle 1; DONE the cycle after the div_ready cycle.
- mthi/mtlo: 0 cycles of latency, no stall.

## Configuration
- DIV_ZERO_FAST_EN defined: div/divu with src_b==0 skips DIV_RUN and goes IDLE→DONE. DONE writes hi=src_a and lo=32'hFFFF_FFFF. The divider is never started.
- DIV_ZERO_FAST_EN undefined: a zero divisor runs through the divider like any other operand; the result is whatever the divider returns.

## Structure
- Shared defines header holds: state encodings (2-bit), Stop/NoStop, DivStart/DivStop, DivResultReady/DivResultNotReady, ZeroWord.
- No sub-module: the counter, capture registers and FSM are inline. The multiplier and divider remain external instances.

## Test plan
- **multu, MUL_LAT=1**: src_a=32'hFFFF_FFFF, src_b=2 → stallreq high cycles 0–2. Cycle 3: hi_we=lo_we=1, hi=1, lo=32'hFFFF_FFFE.
- **div signed**: src_a=-7, src_b=2, model ready after 33 cycles → div_start held until ready. Next cycle: hi=-1, lo=-3, single we pulse.
- **flush in DIV_RUN cycle 10** → div_annul=1 that cycle, IDLE next, no we. A following mult then completes normally.
- **DONE with pipe_stall=1 for 3 cycles** → we only in the first DONE cycle, no restart, IDLE after pipe_stall falls.
- **mthi src_a=32'h1234_5678 in IDLE** → hi_we=1 same cycle, stallreq=0.
- **div src_b=0**:
  - with DIV_ZERO_FAST_EN: DONE at cycle 1 with hi=src_a, lo=32'hFFFF_FFFF, div_start never asserted;
  - without it: div_start asserted at cycle 1.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and types for the HI/LO multiply/divide sequencer.
// Optional build macro DIV_ZERO_FAST_EN is consumed in muldiv_ctrl.sv.
package muldiv_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_MUL_RUN = 2'b01;
  localparam logic [1:0] S_DIV_RUN = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam word_t ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    word_t a;
    word_t b;
    logic  sgn;
  } operands_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the execute stage, the sequencer and the external mul/div units.
// The sequencer takes the slave view; the execute-stage side takes master.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic   flush;
  logic   pipe_stall;
  logic   op_mult;
  logic   op_multu;
  logic   op_div;
  logic   op_divu;
  logic   op_mthi;
  logic   op_mtlo;
  word_t  src_a;
  word_t  src_b;
  logic   stallreq;
  logic   hi_we;
  logic   lo_we;
  word_t  hi_wdata;
  word_t  lo_wdata;
  logic   mul_signed;
  word_t  mul_ina;
  word_t  mul_inb;
  dword_t mul_result;
  logic   div_start;
  logic   div_annul;
  logic   div_signed;
  word_t  div_opa;
  word_t  div_opb;
  dword_t div_result;
  logic   div_ready;

  modport slave (
    input  flush, pipe_stall, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
    input  src_a, src_b, mul_result, div_result, div_ready,
    output stallreq, hi_we, lo_we, hi_wdata, lo_wdata,
    output mul_signed, mul_ina, mul_inb,
    output div_start, div_annul, div_signed, div_opa, div_opb
  );

  modport master (
    output flush, pipe_stall, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
    output src_a, src_b, mul_result, div_result, div_ready,
    input  stallreq, hi_we, lo_we, hi_wdata, lo_wdata,
    input  mul_signed, mul_ina, mul_inb,
    input  div_start, div_annul, div_signed, div_opa, div_opb
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared fixed-latency multiplier and start/ready divider feeding HI/LO.
// DIV_ZERO_FAST_EN: a zero divisor bypasses the divider and writes hi=src_a, lo=all-ones.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  logic [1:0] state;
  logic [3:0] cnt;
  operands_t  cap;
  dword_t     res;
  logic       done_first;

  logic is_mul;
  logic is_div;
  logic accept;
  logic div_zero;

  assign is_mul = bus.op_mult | bus.op_multu;
  assign is_div = bus.op_div | bus.op_divu;
  assign accept = (state == S_IDLE) && !bus.flush && (is_mul || is_div);

`ifdef DIV_ZERO_FAST_EN
  assign div_zero = is_div && (bus.src_b == ZERO_WORD);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap        <= '0;
      res        <= '0;
      done_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap <= '{a: bus.src_a, b: bus.src_b, sgn: bus.op_mult | bus.op_div};
            if (is_mul) begin
              state <= S_MUL_RUN;
              cnt   <= 4'(MUL_LAT);
            end else if (div_zero) begin
              res        <= {bus.src_a, 32'hFFFF_FFFF};
              state      <= S_DONE;
              done_first <= 1'b1;
            end else begin
              state <= S_DIV_RUN;
            end
          end
        end
        S_MUL_RUN: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            res        <= bus.mul_result;
            state      <= S_DONE;
            done_first <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DIV_RUN: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (bus.div_ready == DIV_RESULT_READY) begin
            res        <= bus.div_result;
            state      <= S_DONE;
            done_first <= 1'b1;
          end
        end
        default: begin
          // Holding here while the pipe is stalled keeps the instruction from restarting.
          done_first <= 1'b0;
          if (bus.flush || !bus.pipe_stall) state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.stallreq   = NO_STOP;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hi_wdata   = ZERO_WORD;
    bus.lo_wdata   = ZERO_WORD;
    bus.mul_signed = 1'b0;
    bus.mul_ina    = ZERO_WORD;
    bus.mul_inb    = ZERO_WORD;
    bus.div_start  = DIV_STOP;
    bus.div_annul  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa    = ZERO_WORD;
    bus.div_opb    = ZERO_WORD;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (!bus.flush) begin
            if (bus.op_mthi) begin
              bus.hi_we    = 1'b1;
              bus.hi_wdata = bus.src_a;
            end
            if (bus.op_mtlo) begin
              bus.lo_we    = 1'b1;
              bus.lo_wdata = bus.src_a;
            end
          end
          if (accept) bus.stallreq = STOP;
        end
        S_MUL_RUN: begin
          bus.stallreq   = STOP;
          bus.mul_signed = cap.sgn;
          bus.mul_ina    = cap.a;
          bus.mul_inb    = cap.b;
        end
        S_DIV_RUN: begin
          bus.stallreq   = STOP;
          bus.div_start  = (bus.div_ready == DIV_RESULT_NOT_READY) ? DIV_START : DIV_STOP;
          bus.div_annul  = bus.flush;
          bus.div_signed = cap.sgn;
          bus.div_opa    = cap.a;
          bus.div_opb    = cap.b;
        end
        default: begin
          if (done_first && !bus.flush) begin
            bus.hi_we    = 1'b1;
            bus.lo_we    = 1'b1;
            bus.hi_wdata = res[63:32];
            bus.lo_wdata = res[31:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl with behavioural multiplier/divider models.
// Expected HI/LO values come from plain 64-bit arithmetic on the issued operands.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   div_lat = 1;
  int   div_cnt = 0;
  dword_t mreg = '0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic dword_t ref_mul(input logic sgn, input word_t a, input word_t b);
    longint sp;
    dword_t up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    return sgn ? dword_t'(sp) : up;
  endfunction

  function automatic dword_t ref_div(input logic sgn, input word_t a, input word_t b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // External units: multiplier with LAT-cycle pipeline, divider ready after div_lat start cycles.
  always @(posedge clk) mreg <= ref_mul(bus.mul_signed, bus.mul_ina, bus.mul_inb);
  assign bus.mul_result = mreg;

  always @(posedge clk) begin
    if (rst || bus.div_annul || bus.div_ready) div_cnt <= 0;
    else if (bus.div_start) div_cnt <= div_cnt + 1;
  end
  assign bus.div_ready  = (div_cnt == div_lat);
  assign bus.div_result = bus.div_ready ? ref_div(bus.div_signed, bus.div_opa, bus.div_opb)
                                        : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_ops();
    bus.op_mult = 0; bus.op_multu = 0; bus.op_div = 0;
    bus.op_divu = 0; bus.op_mthi = 0; bus.op_mtlo = 0;
  endtask

  task automatic idle_check(input string tag);
    sample();
    check({tag, "_stall"}, 64'(bus.stallreq), 0);
    check({tag, "_we"}, 64'({bus.hi_we, bus.lo_we}), 0);
    check({tag, "_mulin"}, 64'(bus.mul_ina), 0);
    check({tag, "_divst"}, 64'(bus.div_start), 0);
    step();
  endtask

  // After the first DONE cycle: pipe held dstall cycles in total, then release and return to IDLE.
  task automatic done_tail(input int dstall);
    step();
    for (int k = 1; k <= dstall; k++) begin
      bus.pipe_stall = (k < dstall);
      sample();
      check("done_hold_we", 64'({bus.hi_we, bus.lo_we}), 0);
      check("done_hold_stall", 64'(bus.stallreq), 0);
      check("done_hold_restart", 64'({bus.mul_ina, bus.div_start}), 0);
      step();
    end
    bus.pipe_stall = 0;
    idle_check("after_done");
  endtask

  task automatic run_mul(input logic sgn, input word_t a, input word_t b, input int dstall,
                         input bit flush_last);
    dword_t exp;
    exp = ref_mul(sgn, a, b);
    bus.op_mult = sgn; bus.op_multu = !sgn; bus.src_a = a; bus.src_b = b;
    sample();
    check("mul_accept_stall", 64'(bus.stallreq), 1);
    check("mul_accept_we", 64'(bus.hi_we), 0);
    step();
    clr_ops(); bus.src_a = $urandom; bus.src_b = $urandom;
    bus.pipe_stall = (dstall > 0);
    for (int c = 1; c <= 1 + LAT; c++) begin
      if (flush_last && c == 1 + LAT) bus.flush = 1;
      sample();
      if (!bus.flush) check("mul_run_stall", 64'(bus.stallreq), 1);
      check("mul_run_ops", {bus.mul_ina, bus.mul_inb}, {a, b});
      check("mul_run_sgn", 64'(bus.mul_signed), 64'(sgn));
      check("mul_run_divop", 64'(bus.div_opa), 0);
      check("mul_run_we", 64'(bus.hi_we), 0);
      step();
    end
    bus.flush = 0;
    if (flush_last) begin
      bus.pipe_stall = 0;
      idle_check("mul_flush_last");
      return;
    end
    sample();
    check("mul_done_we", 64'({bus.hi_we, bus.lo_we}), 64'b11);
    check("mul_done_data", {bus.hi_wdata, bus.lo_wdata}, exp);
    check("mul_done_stall", 64'(bus.stallreq), 0);
    check("mul_done_ina", 64'(bus.mul_ina), 0);
    done_tail(dstall);
  endtask

  task automatic run_div(input logic sgn, input word_t a, input word_t b, input int lat,
                         input int dstall, input int flush_at);
    dword_t exp;
    int     exp_n, n;
    bit     fast, done, saw_start, start1;
    exp = ref_div(sgn, a, b);
`ifdef DIV_ZERO_FAST_EN
    fast = (b == 32'h0);
`else
    fast = 1'b0;
`endif
    exp_n = fast ? 1 : lat + 2;
    div_lat = lat;
    bus.op_div = sgn; bus.op_divu = !sgn; bus.src_a = a; bus.src_b = b;
    sample();
    check("div_accept_stall", 64'(bus.stallreq), 1);
    step();
    clr_ops(); bus.src_a = $urandom; bus.src_b = $urandom;
    bus.pipe_stall = (dstall > 0);
    n = 1; done = 0; saw_start = 0; start1 = 0;
    while (n < 200 && !done) begin
      if (n == flush_at) begin
        bus.flush = 1;
        sample();
        check("div_flush_annul", 64'(bus.div_annul), 1);
        check("div_flush_we", 64'({bus.hi_we, bus.lo_we}), 0);
        step();
        bus.flush = 0; bus.pipe_stall = 0;
        idle_check("div_flush_next");
        return;
      end
      sample();
      if (bus.hi_we) begin
        done = 1;
      end else begin
        if (n == 1) start1 = bus.div_start;
        if (bus.div_start) saw_start = 1;
        check("div_run_stall", 64'(bus.stallreq), 1);
        check("div_run_start", 64'(bus.div_start), 64'(!bus.div_ready));
        check("div_run_ops", {bus.div_opa, bus.div_opb}, {a, b});
        check("div_run_sgn", 64'(bus.div_signed), 64'(sgn));
        check("div_run_mulin", 64'(bus.mul_ina), 0);
        step();
        n++;
      end
    end
    check("div_done_cycle", 64'(n), 64'(exp_n));
    check("div_done_we", 64'({bus.hi_we, bus.lo_we}), 64'b11);
    check("div_done_data", {bus.hi_wdata, bus.lo_wdata}, exp);
    check("div_done_stall", 64'(bus.stallreq), 0);
    if (fast) check("div0_no_start", 64'(saw_start), 0);
    else      check("div_start_c1", 64'(start1), 1);
    done_tail(dstall);
  endtask

  task automatic run_mtx(input bit hi, input word_t a, input bit pstall);
    bus.op_mthi = hi; bus.op_mtlo = !hi; bus.src_a = a; bus.pipe_stall = pstall;
    sample();
    check("mtx_we", 64'({bus.hi_we, bus.lo_we}), hi ? 64'b10 : 64'b01);
    check("mtx_data", hi ? 64'(bus.hi_wdata) : 64'(bus.lo_wdata), 64'(a));
    check("mtx_stall", 64'(bus.stallreq), 0);
    step();
    clr_ops(); bus.pipe_stall = 0;
  endtask

  initial begin
    rst = 1;
    bus.flush = 0; bus.pipe_stall = 0;
    clr_ops();
    bus.op_mult = 1; bus.op_mthi = 1;
    bus.src_a = 32'hA5A5_A5A5; bus.src_b = 32'h5A5A_5A5A;
    sample();
    check("rst_stall", 64'(bus.stallreq), 0);
    check("rst_we", 64'({bus.hi_we, bus.lo_we}), 0);
    check("rst_wdata", {bus.hi_wdata, bus.lo_wdata}, 0);
    check("rst_mul", {bus.mul_ina, bus.mul_inb}, 0);
    check("rst_div", 64'({bus.div_start, bus.div_annul, bus.div_signed, bus.mul_signed}), 0);
    step();
    rst = 0; clr_ops();
    idle_check("idle_noop");

    run_mul(1'b0, 32'hFFFF_FFFF, 32'h2, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, 33, 0, 0);
    run_div(1'b1, 32'h0000_1000, 32'h3, 33, 0, 10);
    run_mul(1'b1, 32'hFFFF_FFFD, 32'h7, 0, 1'b0);
    run_mul(1'b1, 32'h0001_0000, 32'h0001_0000, 3, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 4, 3, 0);
    run_mtx(1'b1, 32'h1234_5678, 1'b0);
    run_mtx(1'b1, 32'h0BAD_F00D, 1'b1);
    run_mtx(1'b0, 32'hCAFE_0001, 1'b1);
    run_div(1'b0, 32'hDEAD_0001, 32'h0, 3, 0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1, 0);

    run_div(1'b1, 32'd55, 32'd5, 3, 0, 4);
    run_mul(1'b0, 32'h1234_0000, 32'h10, 0, 1'b1);

    bus.op_mult = 1; bus.flush = 1; bus.src_a = 32'h77;
    sample();
    check("flush_idle_stall", 64'(bus.stallreq), 0);
    step();
    clr_ops(); bus.flush = 0;
    idle_check("flush_idle_next");

    div_lat = 20;
    bus.op_divu = 1; bus.src_a = 32'd999; bus.src_b = 32'd3;
    step();
    clr_ops();
    for (int k = 0; k < 5; k++) step();
    rst = 1;
    sample();
    check("rst_mid_stall", 64'(bus.stallreq), 0);
    check("rst_mid_divop", 64'({bus.div_start, bus.div_opa}), 0);
    step();
    rst = 0;
    idle_check("rst_mid_after");

    for (int i = 0; i < 16; i++) begin
      int    kind;
      word_t a, b;
      kind = $urandom_range(0, 5);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 40));
      case (kind)
        0, 1:    run_mul(kind == 0, a, b, $urandom_range(0, 2), 1'b0);
        2, 3:    run_div(kind == 2, a, b, $urandom_range(1, 8), $urandom_range(0, 2), 0);
        default: run_mtx(kind == 4, a, $urandom_range(0, 1));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
